// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  // Sequencer state, 2-bit encoded.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_e;

  // NOP loaded by flush/bubble consumers (addi x0, x0, 0).
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  // Wait counter width; one extra bit so MAX_WAIT itself is representable.
  function automatic int unsigned wait_cnt_width(input int unsigned max_wait);
    return $clog2(max_wait) + 1;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Control bundle between the stall sequencer and the pipeline stages.
interface pipeline_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);

  // Stage status inputs to the sequencer.
  logic             hazard_detect;
  logic             branch_taken;
  logic             mem_req;
  logic             sram_ready;

  // Stage control outputs from the sequencer.
  logic             freeze_pc;
  logic             freeze_if_id;
  logic             freeze_back;
  logic             flush_if_id;
  logic             bubble_id_exe;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  // Pipeline side: drives status, consumes controls.
  modport master (
    output hazard_detect,
    output branch_taken,
    output mem_req,
    output sram_ready,
    input  freeze_pc,
    input  freeze_if_id,
    input  freeze_back,
    input  flush_if_id,
    input  bubble_id_exe,
    input  mem_timeout,
    input  stall_cycles
  );

  // Sequencer side.
  modport slave (
    input  hazard_detect,
    input  branch_taken,
    input  mem_req,
    input  sram_ready,
    output freeze_pc,
    output freeze_if_id,
    output freeze_back,
    output flush_if_id,
    output bubble_id_exe,
    output mem_timeout,
    output stall_cycles
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter, reusable for performance counters.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // Increment when requested, holding at all-ones.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: merges ID hazard,
// EXE branch-taken and MEM SRAM wait into per-stage freeze/flush/bubble controls.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_stall_ctrl_if.slave bus
);

  localparam int unsigned     WaitW    = wait_cnt_width(MAX_WAIT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;

  logic             frz_front;
  logic             frz_back;
  logic             flush;
  logic             bubble;

  // Next-state and Mealy control decode; first matching rule wins in RUN.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    frz_front     = 1'b0;
    frz_back      = 1'b0;
    flush         = 1'b0;
    bubble        = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.mem_req && !bus.sram_ready) begin
          frz_front  = 1'b1;
          frz_back   = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WaitW'(1);
        end else if (bus.branch_taken) begin
          // The hazarding instruction is squashed, so the branch wins.
          flush  = 1'b1;
          bubble = 1'b1;
        end else if (bus.hazard_detect) begin
          frz_front = 1'b1;
          bubble    = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Branch/hazard inputs are held stable by the freeze; ignore them here.
        if (bus.sram_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          frz_front = 1'b1;
          frz_back  = 1'b1;
          if (wait_cnt_q == WaitLast) begin
            state_d       = TIMEOUT;
            mem_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
          end
        end
      end
      TIMEOUT: begin
        // Dead-end until reset.
        frz_front     = 1'b1;
        frz_back      = 1'b1;
        mem_timeout_d = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // State, wait counter and sticky timeout registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Controls are gated by reset so nothing leaks out while rst is low.
  always_comb begin
    bus.freeze_pc     = rst & frz_front;
    bus.freeze_if_id  = rst & frz_front;
    bus.freeze_back   = rst & frz_back;
    bus.flush_if_id   = rst & flush;
    bus.bubble_id_exe = rst & bubble;
    bus.mem_timeout   = mem_timeout_q;
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.freeze_pc),
    .count (bus.stall_cycles)
  );

endmodule
